// File: rtl/reset_sequencer_if.sv
// Reset sequencer bus: software request/ack plus per-domain reset outputs and status.
interface reset_sequencer_if #(
  parameter int NUM_DOMAINS = 4
);
  logic                   soft_rst_req;
  logic                   soft_rst_ack;
  logic [NUM_DOMAINS-1:0] rst_out;
  logic                   busy;
  logic                   done;

  // Sequencer side
  modport master (
    input  soft_rst_req,
    output soft_rst_ack, rst_out, busy, done
  );

  // Requester / reset consumer side
  modport slave (
    output soft_rst_req,
    input  soft_rst_ack, rst_out, busy, done
  );
endinterface

// File: rtl/reset_sequencer.sv
// Central reset controller: async assert, synchronized release, then staggered
// per-domain release with a programmable gap, plus a software reset path.
module reset_sequencer #(
  parameter int NUM_DOMAINS = 4,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 4,
  parameter int STAGE_DELAY = 8
) (
  input  logic              clk,
  input  logic              rst,
  reset_sequencer_if.master bus
);
  localparam int MAXC = (HOLD_CYCLES > STAGE_DELAY) ? HOLD_CYCLES : STAGE_DELAY;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int IW   = $clog2(NUM_DOMAINS + 1);

  typedef enum logic [1:0] {S_HOLD, S_RELEASE, S_RUN} state_t;

  state_t                 state, state_n;
  logic [CW-1:0]          cnt, cnt_n;
  logic [IW-1:0]          idx, idx_n, idx_inc;
  logic                   ack_q, ack_n;
  logic [SYNC_STAGES-1:0] sync_pipe;
  logic                   sync_ok;

  // Release synchronizer: clears instantly on rst, fills with ones afterwards
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_pipe <= '0;
    else     sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], 1'b1};
  end

  assign sync_ok = sync_pipe[SYNC_STAGES-1];
  assign idx_inc = idx + IW'(1);

  // Sequencer state, counters and ack pulse register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_HOLD;
      cnt   <= '0;
      idx   <= '0;
      ack_q <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      ack_q <= ack_n;
    end
  end

  // Next-state: HOLD waits for sync then counts; RELEASE frees idx..; RUN accepts soft reset
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    ack_n   = 1'b0;
    case (state)
      S_HOLD: begin
        if (sync_ok) begin
          if (cnt == CW'(HOLD_CYCLES - 1)) begin
            cnt_n   = '0;
            idx_n   = '0;
            state_n = (NUM_DOMAINS == 1) ? S_RUN : S_RELEASE;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
      end
      S_RELEASE: begin
        if (cnt == CW'(STAGE_DELAY - 1)) begin
          cnt_n = '0;
          idx_n = idx_inc;
          if (idx_inc == IW'(NUM_DOMAINS - 1)) state_n = S_RUN;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_RUN: begin
        if (bus.soft_rst_req) begin
          state_n = S_HOLD;
          cnt_n   = '0;
          idx_n   = '0;
          ack_n   = 1'b1;
        end
      end
      default: state_n = S_HOLD;
    endcase
  end

  // Domain g is held in HOLD, and in RELEASE until idx has reached it
  for (genvar g = 0; g < NUM_DOMAINS; g++) begin : g_dom
    assign bus.rst_out[g] = (state == S_HOLD) ||
                            ((state == S_RELEASE) && (IW'(g) > idx));
  end

  assign bus.busy         = |bus.rst_out;
  assign bus.done         = (state == S_RUN);
  assign bus.soft_rst_ack = ack_q;
endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench: a timeline model predicts outputs per edge; a monitor compares.
module tb_reset_sequencer;
  localparam int S = 2, H = 4, D = 8, N = 4;

  typedef struct packed {
    logic [N-1:0] rst_out;
    logic         busy;
    logic         done;
    logic         ack;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0, errors = 0;
  int   edge_no = 0;
  int   rst_cnt = 0;
  exp_t exp_q[$];

  reset_sequencer_if #(.NUM_DOMAINS(N)) bus();

  reset_sequencer #(.NUM_DOMAINS(N), .SYNC_STAGES(S), .HOLD_CYCLES(H), .STAGE_DELAY(D))
    dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  always @(posedge rst) rst_cnt++;

  // Domain i is held while fewer than base+i*D edges have passed since the sequence start
  function automatic logic [N-1:0] held(int kk, int b);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = (kk < b + i * D);
    return r;
  endfunction

  function automatic bit in_run(int kk, int b);
    return kk >= b + (N - 1) * D;
  endfunction

  // Reference timeline: k = edges since sequence origin (E0 for power-on, T for soft)
  int k = 0, base = S + H, seen = 0;
  bit active = 0;
  always @(posedge clk) begin
    exp_t e;
    e = '0;
    if (rst) begin
      active = 0;
      seen   = rst_cnt;
    end else if (!active || rst_cnt != seen) begin
      seen = rst_cnt; active = 1; k = 1; base = S + H;
    end else if (in_run(k, base) && bus.soft_rst_req) begin
      k = 0; base = H; e.ack = 1'b1;
    end else if (k < 100000) begin
      k++;
    end
    e.rst_out = rst ? '1 : held(k, base);
    e.busy    = |e.rst_out;
    e.done    = !rst && in_run(k, base);
    exp_q.push_back(e);
    edge_no++;
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
    end
  endtask

  // Monitor: after each clock edge pop and compare; after an async rst edge expect reset values
  initial begin
    int   last = 0;
    exp_t e;
    forever begin
      @(posedge clk or posedge rst);
      #1;
      if (edge_no != last) begin
        last = edge_no;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL scoreboard_empty at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          check("rst_out", 32'(bus.rst_out), 32'(e.rst_out));
          check("busy", 32'(bus.busy), 32'(e.busy));
          check("done", 32'(bus.done), 32'(e.done));
          check("soft_rst_ack", 32'(bus.soft_rst_ack), 32'(e.ack));
        end
      end else begin
        check("async_rst_out", 32'(bus.rst_out), 32'({N{1'b1}}));
        check("async_busy", 32'(bus.busy), 32'd1);
        check("async_done", 32'(bus.done), 32'd0);
        check("async_ack", 32'(bus.soft_rst_ack), 32'd0);
      end
    end
  end

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic por();
    rst = 1'b1;
    cyc(3);
    rst = 1'b0;
  endtask

  // Stimulus
  initial begin
    int r;
    bus.soft_rst_req = 1'b0;
    #1;
    // power-on
    por();
    cyc(40);
    // one-cycle soft reset in RUN
    bus.soft_rst_req = 1'b1; cyc(1); bus.soft_rst_req = 1'b0;
    cyc(35);
    // soft request during RELEASE (sampled at E10) is ignored
    por();
    repeat (9) @(posedge clk);
    @(negedge clk); bus.soft_rst_req = 1'b1;
    @(negedge clk); bus.soft_rst_req = 1'b0;
    cyc(30);
    // rst pulse mid-sequence, just after E18
    por();
    repeat (18) @(posedge clk);
    #3 rst = 1'b1;
    #4 rst = 1'b0;
    cyc(40);
    // soft request held high: periodic re-trigger
    bus.soft_rst_req = 1'b1; cyc(70); bus.soft_rst_req = 1'b0;
    cyc(35);
    // sub-cycle rst glitch in RUN
    @(posedge clk);
    #2 rst = 1'b1;
    #3 rst = 1'b0;
    cyc(40);
    // randomized mix of soft requests, rst pulses and glitches
    repeat (800) begin
      @(negedge clk);
      r = int'($urandom_range(0, 199));
      bus.soft_rst_req = (r < 16);
      if (r == 199) begin
        rst = 1'b1; @(negedge clk); rst = 1'b0;
      end else if (r == 198) begin
        #1 rst = 1'b1;
        #2 rst = 1'b0;
      end
    end
    bus.soft_rst_req = 1'b0;
    cyc(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
